// File: rtl/soc_vjtag_pkg.sv
// Shared types and constants for the virtual-JTAG scan master.
package soc_vjtag_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR
  } state_t;

  localparam logic [1:0] IR_OCIMEM    = 2'b00;
  localparam logic [1:0] IR_TRACEMEM  = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;

  localparam int DR_WIDTH_DEFAULT = 38;

endpackage

// File: rtl/soc_vjtag_tck_gen.sv
// Free-running TCK divider: TCK_DIV clk per half-period, low half first after restart.
// tck_rise/tck_fall are high in the clk cycle whose closing edge flips vji_tck.
module soc_vjtag_tck_gen #(
  parameter int TCK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);

  localparam int PW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(TCK_DIV - 1);

  logic [PW-1:0] phase;
  logic          wrap;

  assign wrap     = (phase == PH_LAST);
  assign tck_rise = wrap && !tck;
  assign tck_fall = wrap && tck;

  always_ff @(posedge clk) begin
    if (!reset_n || restart) begin
      phase <= '0;
      tck   <= 1'b0;
    end else if (wrap) begin
      phase <= '0;
      tck   <= ~tck;
    end else begin
      phase <= phase + 1'b1;
    end
  end

endmodule

// File: rtl/soc_vjtag_scan_master.sv
// Virtual-JTAG initiator: runs UIR/CDR/SDR/UDR to shift one DR word through a debug target.
// Optional SOC_VJTAG_IR_CACHE_EN skips UIR when the requested IR is already loaded.
module soc_vjtag_scan_master
  import soc_vjtag_pkg::*;
#(
  parameter int DR_WIDTH = DR_WIDTH_DEFAULT,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic                vji_tdo,
  input  logic [IR_WIDTH-1:0] vji_ir_out
);

  localparam int BW = $clog2(DR_WIDTH + 1);

  state_t              state, state_nxt;
  logic                accept;
  logic                tck_rise, tck_fall;
  logic                skip_uir;
  logic [DR_WIDTH-1:0] shreg, shreg_shift;
  logic [BW-1:0]       bit_cnt;

  assign accept = cmd_valid && cmd_ready;

  soc_vjtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .restart  (accept),
    .tck      (vji_tck),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

`ifdef SOC_VJTAG_IR_CACHE_EN
  // vji_ir_in already holds the last IR loaded; only its validity needs tracking.
  logic ir_cache_vld;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ir_cache_vld <= 1'b0;
    end else if (accept && !skip_uir) begin
      ir_cache_vld <= 1'b1;
    end
  end

  assign skip_uir = ir_cache_vld && (cmd_ir == vji_ir_in);
`else
  assign skip_uir = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)   state_nxt = skip_uir ? ST_CDR : ST_UIR;
      ST_UIR:  if (tck_fall) state_nxt = ST_CDR;
      ST_CDR:  if (tck_fall) state_nxt = ST_SDR;
      ST_SDR:  if (tck_fall && (bit_cnt == BW'(DR_WIDTH))) state_nxt = ST_UDR;
      ST_UDR:  if (tck_fall) state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE);
    vji_rti   = (state == ST_IDLE);
    vji_uir   = (state == ST_UIR);
    vji_cdr   = (state == ST_CDR);
    vji_sdr   = (state == ST_SDR);
    vji_udr   = (state == ST_UDR);
  end

  // Shift right, new TDO bit enters at the MSB; written this way so DR_WIDTH=1 works.
  always_comb begin
    shreg_shift               = shreg >> 1;
    shreg_shift[DR_WIDTH-1]   = vji_tdo;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      vji_tdi    <= 1'b0;
      vji_ir_in  <= '0;
      rsp_ir_out <= '0;
      rsp_dr     <= '0;
      rsp_valid  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        shreg   <= cmd_dr;
        bit_cnt <= '0;
        if (!skip_uir) vji_ir_in <= cmd_ir;
      end
      if (state == ST_CDR && tck_rise) rsp_ir_out <= vji_ir_out;
      if (state == ST_SDR && tck_rise) begin
        shreg   <= shreg_shift;
        bit_cnt <= bit_cnt + 1'b1;
      end
      // TDI moves only on falling strobes so it is stable across each TCK rise.
      if (tck_fall && state != ST_IDLE) begin
        vji_tdi <= (state_nxt == ST_SDR) ? shreg[0] : 1'b0;
      end
      if (state == ST_UDR && tck_fall) begin
        rsp_dr    <= shreg;
        rsp_valid <= 1'b1;
      end
    end
  end

endmodule
